// File: rtl/spram_arb2_pkg.sv
// Shared encodings for the two-requester spram arbiter: FSM states and the
// polarity of the spram chip-select and direction pins.
package spram_arb2_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  localparam logic CS_ON  = 1'b0;
  localparam logic CS_OFF = 1'b1;
  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

endpackage

// File: rtl/spram_arb2_if.sv
// One requester's command/response channel into the spram arbiter.
// The master modport is the datapath client; the slave modport is the arbiter.
interface spram_arb2_if
  import spram_arb2_pkg::*;
#(
  parameter int WD = 8,
  parameter int AW = 4
);

  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [WD-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [WD-1:0] rdata;

  modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/spram_arb2.sv
// Round-robin controller for one external spram: zero-fills the RAM after reset,
// then serialises A/B commands onto the single port with an IDLE/ACC pair per access.
module spram_arb2
  import spram_arb2_pkg::*;
#(
  parameter int WD      = 8,
  parameter int DP      = 16,
  parameter int AW      = $clog2(DP),
  parameter int INIT_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  spram_arb2_if.slave   a,
  spram_arb2_if.slave   b,
  output logic          init_done,
  output logic          ram_cs_n,
  output logic          ram_w_r_n,
  output logic [AW-1:0] ram_addr,
  output logic [WD-1:0] ram_din,
  input  logic [WD-1:0] ram_dout
);

  localparam state_t        RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_IDLE;
  localparam logic          RST_DONE  = (INIT_EN == 0);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DP - 1);

  state_t        state_q, state_d;
  logic          cs_d, wr_d;
  logic [AW-1:0] addr_d;
  logic [WD-1:0] din_d;
  logic          a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic          a_rv_q, a_rv_d, b_rv_q, b_rv_d;
  logic          done_d;
  logic          ptr_b_q, ptr_b_d;
  logic          owner_b_q, owner_b_d;
  logic          any_req, win_b, fill_last;

  assign any_req   = a.req | b.req;
  assign win_b     = b.req & (~a.req | ptr_b_q);
  assign fill_last = (ram_cs_n == CS_ON) && (ram_addr == LAST_ADDR);

  assign a.gnt    = a_gnt_q;
  assign b.gnt    = b_gnt_q;
  assign a.rvalid = a_rv_q;
  assign b.rvalid = b_rv_q;
  assign a.rdata  = ram_dout;
  assign b.rdata  = ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      ram_cs_n  <= CS_OFF;
      ram_w_r_n <= DIR_RD;
      ram_addr  <= '0;
      ram_din   <= '0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_rv_q    <= 1'b0;
      b_rv_q    <= 1'b0;
      init_done <= RST_DONE;
      ptr_b_q   <= 1'b0;
      owner_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_cs_n  <= cs_d;
      ram_w_r_n <= wr_d;
      ram_addr  <= addr_d;
      ram_din   <= din_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_rv_q    <= a_rv_d;
      b_rv_q    <= b_rv_d;
      init_done <= done_d;
      ptr_b_q   <= ptr_b_d;
      owner_b_q <= owner_b_d;
    end
  end

  // ACC always falls back to IDLE so a requester gets a cycle to drop its req.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (fill_last) state_d = ST_IDLE;
      ST_IDLE: if (any_req) state_d = ST_ACC;
      ST_ACC:  state_d = ST_IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    cs_d      = CS_OFF;
    wr_d      = ram_w_r_n;
    addr_d    = ram_addr;
    din_d     = ram_din;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    a_rv_d    = 1'b0;
    b_rv_d    = 1'b0;
    done_d    = init_done;
    ptr_b_d   = ptr_b_q;
    owner_b_d = owner_b_q;
    unique case (state_q)
      ST_INIT: begin
        // The chip select doubles as "fill started", so the first word is address 0.
        if (fill_last) begin
          done_d = 1'b1;
        end else begin
          cs_d   = CS_ON;
          wr_d   = DIR_WR;
          din_d  = '0;
          addr_d = (ram_cs_n == CS_ON) ? ram_addr + 1'b1 : '0;
        end
      end
      ST_IDLE: begin
        if (any_req) begin
          cs_d      = CS_ON;
          wr_d      = win_b ? b.wr    : a.wr;
          addr_d    = win_b ? b.addr  : a.addr;
          din_d     = win_b ? b.wdata : a.wdata;
          a_gnt_d   = ~win_b;
          b_gnt_d   = win_b;
          owner_b_d = win_b;
          ptr_b_d   = ~win_b;
        end
      end
      ST_ACC: begin
        a_rv_d = ~owner_b_q & (ram_w_r_n == DIR_RD);
        b_rv_d =  owner_b_q & (ram_w_r_n == DIR_RD);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spram_arb2.sv
// Bench for spram_arb2: an spram model behind the block, a transaction-level
// reference model compared every cycle, directed cases and a random phase.
module tb_spram_arb2;

  localparam int DP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst0_n = 1'b0;
  logic       init_done, ram_cs_n, ram_w_r_n;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       init_done0, ram_cs0_n, ram_w_r0_n;
  logic [3:0] ram_addr0;
  logic [7:0] ram_din0;
  logic [7:0] ram_dout0 = 8'h3C;
  logic [7:0] ram_mem [DP];
  bit         seed_mem = 1'b1;

  int errors = 0;
  int checks = 0;

  spram_arb2_if #(.WD(8), .AW(4)) a_if ();
  spram_arb2_if #(.WD(8), .AW(4)) b_if ();
  spram_arb2_if #(.WD(8), .AW(4)) a0_if ();
  spram_arb2_if #(.WD(8), .AW(4)) b0_if ();

  spram_arb2 #(.WD(8), .DP(DP), .AW(4), .INIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .a(a_if), .b(b_if), .init_done(init_done),
    .ram_cs_n(ram_cs_n), .ram_w_r_n(ram_w_r_n), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  spram_arb2 #(.WD(8), .DP(DP), .AW(4), .INIT_EN(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .a(a0_if), .b(b0_if), .init_done(init_done0),
    .ram_cs_n(ram_cs0_n), .ram_w_r_n(ram_w_r0_n), .ram_addr(ram_addr0),
    .ram_din(ram_din0), .ram_dout(ram_dout0)
  );

  always #5 clk = ~clk;

  // External spram: write on cs, read data appears the cycle after a read access.
  always @(posedge clk) begin
    if (seed_mem) begin
      foreach (ram_mem[i]) ram_mem[i] <= 8'hEE;
    end else if (!ram_cs_n) begin
      if (ram_w_r_n) ram_mem[ram_addr] <= ram_din;
      else ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a flat memory plus "which cycle shows what" bookkeeping.
  int         cyc = -1;
  int         gnt_at = -10, rv_at = -10, next_ok = 0;
  bit         g_b, g_wr, rv_b, ptr_b;
  logic [3:0] g_addr;
  logic [7:0] g_wd, rv_data;
  logic [7:0] model_mem [DP];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = -1; gnt_at = -10; rv_at = -10; next_ok = 0; ptr_b = 1'b0;
      foreach (model_mem[i]) model_mem[i] = 8'h00;
    end else begin
      cyc++;
      if (cyc >= DP + 1 && cyc >= next_ok && (a_if.req || b_if.req)) begin
        g_b     = b_if.req && (!a_if.req || ptr_b);
        g_wr    = g_b ? b_if.wr : a_if.wr;
        g_addr  = g_b ? b_if.addr : a_if.addr;
        g_wd    = g_b ? b_if.wdata : a_if.wdata;
        gnt_at  = cyc;
        ptr_b   = !g_b;
        next_ok = cyc + 2;
        if (g_wr) begin
          model_mem[g_addr] = g_wd;
        end else begin
          rv_at   = cyc + 1;
          rv_b    = g_b;
          rv_data = model_mem[g_addr];
        end
      end
    end
  end

  logic [7:0] last_a_rd, last_b_rd;
  int         last_a_rv_cyc = -1, last_b_rv_cyc = -1, b_rv_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && cyc >= 0) begin
      if (cyc < DP) begin
        check_output("fill_cs_n", 32'(ram_cs_n), 32'd0);
        check_output("fill_addr", 32'(ram_addr), 32'(cyc));
        check_output("fill_w_r_n", 32'(ram_w_r_n), 32'd1);
        check_output("fill_din", 32'(ram_din), 32'd0);
        check_output("fill_done", 32'(init_done), 32'd0);
      end else begin
        check_output("init_done", 32'(init_done), 32'd1);
        if (cyc == gnt_at) begin
          check_output("acc_cs_n", 32'(ram_cs_n), 32'd0);
          check_output("acc_addr", 32'(ram_addr), 32'(g_addr));
          check_output("acc_w_r_n", 32'(ram_w_r_n), 32'(g_wr));
          if (g_wr) check_output("acc_din", 32'(ram_din), 32'(g_wd));
        end else begin
          check_output("idle_cs_n", 32'(ram_cs_n), 32'd1);
        end
      end
      check_output("a_gnt", 32'(a_if.gnt), 32'(cyc == gnt_at && !g_b));
      check_output("b_gnt", 32'(b_if.gnt), 32'(cyc == gnt_at && g_b));
      check_output("a_rvalid", 32'(a_if.rvalid), 32'(cyc == rv_at && !rv_b));
      check_output("b_rvalid", 32'(b_if.rvalid), 32'(cyc == rv_at && rv_b));
      if (cyc == rv_at) check_output("rdata", 32'(rv_b ? b_if.rdata : a_if.rdata), 32'(rv_data));
      if (a_if.rvalid) begin last_a_rd = a_if.rdata; last_a_rv_cyc = cyc; end
      if (b_if.rvalid) begin last_b_rd = b_if.rdata; last_b_rv_cyc = cyc; b_rv_cnt++; end
    end
  end

  int st_cyc, a_g_cyc, b_g_cyc;

  // Present one command per requester, drop each req on its grant, wait out rvalid.
  task automatic apply_stimulus(input bit a_on, input bit a_w, input logic [3:0] a_ad,
                                input logic [7:0] a_d, input bit b_on, input bit b_w,
                                input logic [3:0] b_ad, input logic [7:0] b_d);
    int n = 0;
    st_cyc = cyc; a_g_cyc = -1; b_g_cyc = -1;
    a_if.req = a_on; a_if.wr = a_w; a_if.addr = a_ad; a_if.wdata = a_d;
    b_if.req = b_on; b_if.wr = b_w; b_if.addr = b_ad; b_if.wdata = b_d;
    while ((a_if.req || b_if.req) && n < 40) begin
      @(posedge clk); #2; n++;
      if (a_if.req && a_if.gnt) begin a_if.req = 1'b0; a_g_cyc = cyc; end
      if (b_if.req && b_if.gnt) begin b_if.req = 1'b0; b_g_cyc = cyc; end
    end
    check_output("grant_timeout", 32'(a_if.req | b_if.req), 32'd0);
    a_if.req = 1'b0; b_if.req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check_output("rst_cs_n", 32'(ram_cs_n), 32'd1);
    check_output("rst_w_r_n", 32'(ram_w_r_n), 32'd0);
    check_output("rst_addr", 32'(ram_addr), 32'd0);
    check_output("rst_din", 32'(ram_din), 32'd0);
    check_output("rst_gnt", 32'({a_if.gnt, b_if.gnt}), 32'd0);
    check_output("rst_rvalid", 32'({a_if.rvalid, b_if.rvalid}), 32'd0);
    check_output("rst_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!init_done && n < 60) begin @(posedge clk); #2; n++; end
    check_output("done_cycle", 32'(cyc), 32'(DP));
  endtask

  task automatic wait_cycle(input int target);
    int n = 0;
    while (cyc != target && n < 60) begin @(posedge clk); #2; n++; end
    check_output("wait_cycle", 32'(cyc), 32'(target));
  endtask

  task automatic rand_phase(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #2;
      if (a_if.req && a_if.gnt) a_if.req = 1'b0;
      else if (a_if.req && $urandom_range(15, 0) == 0) a_if.req = 1'b0;
      else if (!a_if.req && $urandom_range(2, 0) == 0) begin
        a_if.req = 1'b1; a_if.wr = 1'($urandom_range(1, 0));
        a_if.addr = 4'($urandom_range(15, 0)); a_if.wdata = 8'($urandom);
      end
      if (b_if.req && b_if.gnt) b_if.req = 1'b0;
      else if (b_if.req && $urandom_range(15, 0) == 0) b_if.req = 1'b0;
      else if (!b_if.req && $urandom_range(2, 0) == 0) begin
        b_if.req = 1'b1; b_if.wr = 1'($urandom_range(1, 0));
        b_if.addr = 4'($urandom_range(15, 0)); b_if.wdata = 8'($urandom);
      end
    end
    a_if.req = 1'b0; b_if.req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int bcnt;
    a_if.req = 0; a_if.wr = 0; a_if.addr = 0; a_if.wdata = 0;
    b_if.req = 0; b_if.wr = 0; b_if.addr = 0; b_if.wdata = 0;
    a0_if.req = 0; a0_if.wr = 0; a0_if.addr = 0; a0_if.wdata = 0;
    b0_if.req = 0; b0_if.wr = 0; b0_if.addr = 0; b0_if.wdata = 0;
    repeat (2) @(posedge clk);
    #2;
    seed_mem = 1'b0;
    $display("[TB] reset and zero-fill");
    reset_dut();
    wait_done();

    $display("[TB] simultaneous requests alternate A,B");
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 0, 4'd0, 8'h00, 1, 0, 4'd0, 8'h00);
      check_output("alt_a_first", 32'(b_g_cyc - a_g_cyc), 32'd2);
      check_output("alt_read0", 32'(last_a_rd), 32'h00);
    end

    $display("[TB] A write and B read of one address in the same cycle");
    apply_stimulus(1, 1, 4'd7, 8'h5A, 1, 0, 4'd7, 8'h00);
    check_output("wr_rd_gap", 32'(b_g_cyc - a_g_cyc), 32'd2);
    check_output("wr_rd_data", 32'(last_b_rd), 32'h5A);
    check_output("wr_rd_rv_cyc", 32'(last_b_rv_cyc), 32'(b_g_cyc + 1));

    $display("[TB] A reads every address after fill");
    for (int i = 0; i < DP; i++) begin
      apply_stimulus(1, 0, 4'(i), 8'h00, 0, 0, 4'd0, 8'h00);
      check_output("fill_read", 32'(last_a_rd), (i == 7) ? 32'h5A : 32'h00);
    end

    $display("[TB] A write then read of addr 3");
    bcnt = b_rv_cnt;
    apply_stimulus(1, 1, 4'd3, 8'hA3, 0, 0, 4'd0, 8'h00);
    apply_stimulus(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    check_output("rd_gnt_lat", 32'(a_g_cyc), 32'(st_cyc + 1));
    check_output("rd_rv_lat", 32'(last_a_rv_cyc), 32'(a_g_cyc + 1));
    check_output("rd_data", 32'(last_a_rd), 32'hA3);
    check_output("no_b_rvalid", 32'(b_rv_cnt), 32'(bcnt));

    $display("[TB] requests during fill");
    reset_dut();
    a_if.req = 1'b1; a_if.wr = 1'b0; a_if.addr = 4'd5;
    repeat (5) @(posedge clk);
    #2;
    a_if.req = 1'b0;
    apply_stimulus(1, 0, 4'd5, 8'h00, 0, 0, 4'd0, 8'h00);
    check_output("first_gnt_cyc", 32'(a_g_cyc), 32'(DP + 1));

    $display("[TB] reset during fill and during an access");
    reset_dut();
    wait_cycle(9);
    check_output("fill_at_9", 32'(ram_addr), 32'd9);
    reset_dut();
    wait_done();
    a_if.req = 1'b1; a_if.wr = 1'b1; a_if.addr = 4'd2; a_if.wdata = 8'h77;
    @(posedge clk); #2;
    check_output("acc_before_rst", 32'(a_if.gnt), 32'd1);
    a_if.req = 1'b0;
    reset_dut();
    wait_done();
    apply_stimulus(1, 0, 4'd2, 8'h00, 0, 0, 4'd0, 8'h00);
    check_output("aborted_write", 32'(last_a_rd), 32'h00);

    $display("[TB] random traffic");
    rand_phase(600);

    $display("[TB] INIT_EN=0 instance");
    #1;
    check_output("noinit_done_rst", 32'(init_done0), 32'd1);
    check_output("noinit_cs_rst", 32'(ram_cs0_n), 32'd1);
    a0_if.req = 1'b1; a0_if.wr = 1'b1; a0_if.addr = 4'd4; a0_if.wdata = 8'hC3;
    @(posedge clk); #2;
    rst0_n = 1'b1;
    @(posedge clk); #2;
    check_output("noinit_a_gnt", 32'(a0_if.gnt), 32'd1);
    check_output("noinit_b_gnt", 32'(b0_if.gnt), 32'd0);
    check_output("noinit_cs", 32'(ram_cs0_n), 32'd0);
    check_output("noinit_wr", 32'(ram_w_r0_n), 32'd1);
    check_output("noinit_addr", 32'(ram_addr0), 32'd4);
    check_output("noinit_din", 32'(ram_din0), 32'hC3);
    a0_if.req = 1'b0;
    @(posedge clk); #2;
    check_output("noinit_rvalid", 32'({a0_if.rvalid, b0_if.rvalid}), 32'd0);
    check_output("noinit_rdata", 32'({a0_if.rdata, b0_if.rdata}), 32'h3C3C);
    check_output("noinit_done", 32'(init_done0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
